// File: rtl/dsp_cfg_loader.sv
// Programs the DSP tile's mode word into its RS-latch configuration memory,
// one latch at a time, with setup / wl-pulse / hold phases on the bl/wl bus.
module dsp_cfg_loader #(
  parameter int NUM_BITS  = 85,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic                dsp_cfg_clk,
  input  logic                dsp_cfg_rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [0:NUM_BITS-1] cfg_word,
  output logic [0:NUM_BITS-1] bl,
  output logic [0:NUM_BITS-1] wl,
  output logic                dsp_lreset,
  output logic                cfg_busy,
  output logic                cfg_done
);

  localparam int IDX_W   = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
  localparam int MAX_SP  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int MAX_CYC = (MAX_SP > HOLD_CYC) ? MAX_SP : HOLD_CYC;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, DONE} state_t;

  state_t              state, state_nxt;
  logic [IDX_W-1:0]    idx, idx_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [0:NUM_BITS-1] shadow, shadow_nxt;
  logic [0:NUM_BITS-1] bl_nxt, wl_nxt;
  logic                active_nxt;

  assign cfg_ready = (state == IDLE) && !dsp_cfg_rst;

  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    cnt_nxt    = cnt;
    shadow_nxt = shadow;
    case (state)
      IDLE: begin
        if (cfg_valid) begin
          state_nxt  = SETUP;
          idx_nxt    = '0;
          cnt_nxt    = '0;
          shadow_nxt = cfg_word;
        end
      end
      SETUP: begin
        if (cnt == CNT_W'(SETUP_CYC - 1)) begin
          state_nxt = PULSE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      PULSE: begin
        if (cnt == CNT_W'(PULSE_CYC - 1)) begin
          state_nxt = HOLD;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      HOLD: begin
        if (cnt == CNT_W'(HOLD_CYC - 1)) begin
          cnt_nxt = '0;
          if (idx == IDX_W'(NUM_BITS - 1)) begin
            state_nxt = DONE;
          end else begin
            state_nxt = SETUP;
            idx_nxt   = idx + IDX_W'(1);
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // Outputs are decoded from the next state so the bus is driven straight
    // from flops; bl only moves on SETUP entry, when wl is already low.
    active_nxt = (state_nxt == SETUP) || (state_nxt == PULSE) || (state_nxt == HOLD);
    bl_nxt     = '0;
    wl_nxt     = '0;
    if (active_nxt) bl_nxt[idx_nxt] = shadow_nxt[idx_nxt];
    if (state_nxt == PULSE) wl_nxt[idx_nxt] = 1'b1;
  end

  always_ff @(posedge dsp_cfg_clk) begin
    if (dsp_cfg_rst) begin
      state      <= IDLE;
      idx        <= '0;
      cnt        <= '0;
      bl         <= '0;
      wl         <= '0;
      dsp_lreset <= 1'b0;
      cfg_busy   <= 1'b0;
      cfg_done   <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      cnt        <= cnt_nxt;
      bl         <= bl_nxt;
      wl         <= wl_nxt;
      dsp_lreset <= active_nxt || (state_nxt == DONE);
      cfg_busy   <= active_nxt || (state_nxt == DONE);
      cfg_done   <= (state_nxt == DONE);
    end
  end

  // Shadow word is pure data and only meaningful after an accept.
  always_ff @(posedge dsp_cfg_clk) begin
    shadow <= shadow_nxt;
  end

endmodule

// File: tb/tb_dsp_cfg_loader.sv
// Bench for dsp_cfg_loader: two instances (default and 2/3/1 phase timing),
// a cycle-level reference model and a cfg_done timing scoreboard.
module tb_dsp_cfg_loader;

  localparam int N = 85;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_i[2]  = '{1'b1, 1'b1};
  logic         vld_i[2]  = '{1'b0, 1'b0};
  logic [0:N-1] word_i[2] = '{'0, '0};

  logic         rdy0, lr0, busy0, done0, rdy1, lr1, busy1, done1;
  logic [0:N-1] bl0, wl0, bl1, wl1;

  dsp_cfg_loader #(.NUM_BITS(N)) u0 (
    .dsp_cfg_clk(clk), .dsp_cfg_rst(rst_i[0]), .cfg_valid(vld_i[0]),
    .cfg_ready(rdy0), .cfg_word(word_i[0]), .bl(bl0), .wl(wl0),
    .dsp_lreset(lr0), .cfg_busy(busy0), .cfg_done(done0));

  dsp_cfg_loader #(.NUM_BITS(N), .SETUP_CYC(2), .PULSE_CYC(3), .HOLD_CYC(1)) u1 (
    .dsp_cfg_clk(clk), .dsp_cfg_rst(rst_i[1]), .cfg_valid(vld_i[1]),
    .cfg_ready(rdy1), .cfg_word(word_i[1]), .bl(bl1), .wl(wl1),
    .dsp_lreset(lr1), .cfg_busy(busy1), .cfg_done(done1));

  int sc[2] = '{1, 2};
  int pc[2] = '{2, 3};
  int hc[2] = '{1, 1};

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  // Reference model state: act = a word is being programmed, tm = cycles
  // since the accepting edge (0 = first cycle after it).
  bit           act[2]  = '{1'b0, 1'b0};
  bit           seen[2] = '{1'b0, 1'b0};
  int           tm[2]   = '{0, 0};
  int           acc[2]  = '{0, 0};
  logic [0:N-1] wm[2];
  int           qd[2][$];

  function automatic int per(int u);
    return sc[u] + pc[u] + hc[u];
  endfunction

  function automatic void chk(string nm, bit ok, string det);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: %s", nm, det);
  endfunction

  function automatic logic [0:N-1] rnd_word();
    logic [0:95] t;
    t = {$urandom, $urandom, $urandom};
    return t[0:N-1];
  endfunction

  always @(posedge clk) begin
    cyc++;
    for (int u = 0; u < 2; u++) begin
      if (rst_i[u]) begin
        act[u]  = 1'b0;
        seen[u] = 1'b1;
        qd[u].delete();
      end else if (act[u]) begin
        if (tm[u] == N * per(u)) act[u] = 1'b0;
        else tm[u]++;
      end else if (vld_i[u]) begin
        act[u] = 1'b1;
        tm[u]  = 0;
        wm[u]  = word_i[u];
        acc[u]++;
        qd[u].push_back(cyc + N * per(u));
      end
    end
  end

  always @(negedge clk) begin
    logic [0:N-1] gb, gw, eb, ew;
    logic gr, gl, gy, gd, er, el, ey, ed;
    int t_per, bi, ph, e;
    for (int u = 0; u < 2; u++) begin
      if (u == 0) begin gb = bl0; gw = wl0; gr = rdy0; gl = lr0; gy = busy0; gd = done0; end
      else        begin gb = bl1; gw = wl1; gr = rdy1; gl = lr1; gy = busy1; gd = done1; end
      if (seen[u]) begin
        t_per = per(u);
        eb = '0; ew = '0; er = 1'b0; el = 1'b0; ey = 1'b0; ed = 1'b0;
        if (!act[u]) begin
          er = !rst_i[u];
        end else begin
          el = 1'b1;
          ey = 1'b1;
          if (tm[u] < N * t_per) begin
            bi = tm[u] / t_per;
            ph = tm[u] % t_per;
            eb[bi] = wm[u][bi];
            if (ph >= sc[u] && ph < sc[u] + pc[u]) ew[bi] = 1'b1;
          end else begin
            ed = 1'b1;
          end
        end
        chk($sformatf("u%0d_outputs_cyc%0d", u, cyc),
            {gb, gw, gr, gl, gy, gd} === {eb, ew, er, el, ey, ed},
            $sformatf("got bl=%h wl=%h rdy=%b lr=%b busy=%b done=%b, want bl=%h wl=%h rdy=%b lr=%b busy=%b done=%b",
                      gb, gw, gr, gl, gy, gd, eb, ew, er, el, ey, ed));
        chk($sformatf("u%0d_wl_onehot_cyc%0d", u, cyc), $countones(gw) <= 1,
            $sformatf("wl=%h has %0d bits set, want <=1", gw, $countones(gw)));
        if (gd === 1'b1) begin
          if (qd[u].size() == 0) begin
            chk($sformatf("u%0d_done_unexpected", u), 1'b0,
                $sformatf("cfg_done at cycle %0d with no load outstanding", cyc));
          end else begin
            e = qd[u].pop_front();
            chk($sformatf("u%0d_done_time", u), cyc == e,
                $sformatf("cfg_done after edge %0d, want %0d", cyc, e));
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic load(int u, logic [0:N-1] w, bit keep);
    int n;
    bit got;
    n = acc[u];
    got = 1'b0;
    vld_i[u]  = 1'b1;
    word_i[u] = w;
    for (int c = 0; c < 3000 && !got; c++) begin
      step();
      if (acc[u] != n) got = 1'b1;
    end
    if (!got) chk($sformatf("u%0d_accept_timeout", u), 1'b0, "no accept within 3000 cycles");
    if (!keep) vld_i[u] = 1'b0;
  endtask

  task automatic wait_idle(int u);
    for (int c = 0; c < 4000 && act[u]; c++) step();
    if (act[u]) chk($sformatf("u%0d_idle_timeout", u), 1'b0, "still busy after 4000 cycles");
  endtask

  task automatic do_reset(int u, int n);
    rst_i[u]  = 1'b1;
    vld_i[u]  = 1'b1;
    word_i[u] = rnd_word();
    repeat (n) step();
    rst_i[u] = 1'b0;
    vld_i[u] = 1'b0;
  endtask

  task automatic run0();
    logic [0:N-1] w;
    do_reset(0, 3);
    repeat (2) step();
    for (int i = 0; i < N; i++) w[i] = 1'(i % 2);
    load(0, w, 1'b0);
    wait_idle(0);
    load(0, '1, 1'b0);
    wait_idle(0);
    // Busy-time noise on valid and word must not disturb the captured word.
    load(0, rnd_word(), 1'b0);
    for (int c = 0; c < 5000 && act[0] && tm[0] < N * per(0) - 3; c++) begin
      vld_i[0]  = 1'($urandom_range(0, 1));
      word_i[0] = rnd_word();
      step();
    end
    vld_i[0] = 1'b0;
    wait_idle(0);
    for (int j = 0; j < 3; j++) load(0, rnd_word(), 1'b1);
    vld_i[0] = 1'b0;
    wait_idle(0);
    // Abort during the first PULSE cycle of bit 40, then reload.
    load(0, rnd_word(), 1'b0);
    for (int c = 0; c < 3000 && !(act[0] && tm[0] == 40 * per(0) + sc[0]); c++) step();
    rst_i[0] = 1'b1;
    step();
    rst_i[0] = 1'b0;
    repeat (2) step();
    load(0, rnd_word(), 1'b0);
    wait_idle(0);
  endtask

  task automatic run1();
    logic [0:N-1] w;
    do_reset(1, 2);
    step();
    load(1, rnd_word(), 1'b0);
    wait_idle(1);
    for (int i = 0; i < N; i++) w[i] = 1'((i + 1) % 2);
    load(1, w, 1'b0);
    wait_idle(1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    fork
      run0();
      run1();
    join
    repeat (3) step();
    for (int u = 0; u < 2; u++)
      chk($sformatf("u%0d_done_outstanding", u), qd[u].size() == 0,
          $sformatf("%0d expected cfg_done pulses never seen, want 0", qd[u].size()));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
